// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces raw push-buttons against the
// slow_clk sampling timebase, turns presses into one-cycle pulses, and queues
// them as a single key event under a valid/ack handshake.
module button_conditioner #(
   parameter int N_BTN          = 5,
   parameter int STABLE_SAMPLES = 4,
   parameter int CODE_W         = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              slow_clk,
   input  logic [N_BTN-1:0]  btn_raw,
   input  logic              key_ack,
   output logic [N_BTN-1:0]  btn_level,
   output logic [N_BTN-1:0]  btn_pulse,
   output logic              key_valid,
   output logic [CODE_W-1:0] key_code,
   output logic              overrun
);

   logic              slow_s1_q, slow_s1_d;
   logic              slow_s2_q, slow_s2_d;
   logic              slow_dly_q, slow_dly_d;
   logic [N_BTN-1:0]  btn_s1_q, btn_s1_d;
   logic [N_BTN-1:0]  btn_s2_q, btn_s2_d;
   logic [7:0]        cnt_q [N_BTN];
   logic [7:0]        cnt_d [N_BTN];
   logic [N_BTN-1:0]  level_q, level_d;
   logic [N_BTN-1:0]  pulse_q, pulse_d;
   logic              valid_q, valid_d;
   logic [CODE_W-1:0] code_q, code_d;
   logic              overrun_q, overrun_d;
   logic              tick;

   // Synchronizer chains and slow_clk rising-edge detect.
   always_comb begin
      slow_s1_d  = slow_clk;
      slow_s2_d  = slow_s1_q;
      slow_dly_d = slow_s2_q;
      btn_s1_d   = btn_raw;
      btn_s2_d   = btn_s1_q;
      tick       = slow_s2_q & ~slow_dly_q;
   end

   // Debounce: a level flips only after STABLE_SAMPLES consecutive differing ticks.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (tick) begin
         for (int unsigned i = 0; i < N_BTN; i++) begin
            if (btn_s2_q[i] == level_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == 8'(STABLE_SAMPLES - 1)) begin
               level_d[i] = btn_s2_q[i];
               cnt_d[i]   = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 8'd1;
            end
         end
      end
      pulse_d = level_d & ~level_q;
   end

   // Event slot: accept lowest pulsing index when free, flag drops as overrun.
   always_comb begin
      logic              any_p;
      logic              multi_p;
      logic              found;
      logic [CODE_W-1:0] low_idx;
      logic              slot_free;
      logic              ack_hit;
      logic              drop;

      any_p   = |pulse_q;
      multi_p = 1'b0;
      found   = 1'b0;
      low_idx = '0;
      for (int unsigned i = 0; i < N_BTN; i++) begin
         if (pulse_q[i]) begin
            if (found) begin
               multi_p = 1'b1;
            end else begin
               low_idx = CODE_W'(i);
               found   = 1'b1;
            end
         end
      end

      slot_free = ~valid_q | key_ack;
      ack_hit   = key_ack & valid_q;
      drop      = any_p & (~slot_free | multi_p);

      valid_d   = valid_q;
      code_d    = code_q;
      overrun_d = overrun_q;

      if (any_p) begin
         if (slot_free) begin
            valid_d = 1'b1;
            code_d  = low_idx;
         end
      end else if (ack_hit) begin
         valid_d = 1'b0;
      end

      if (drop) begin
         overrun_d = 1'b1;
      end else if (ack_hit) begin
         overrun_d = 1'b0;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slow_s1_q  <= 1'b0;
         slow_s2_q  <= 1'b0;
         slow_dly_q <= 1'b0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         cnt_q      <= '{default: '0};
         level_q    <= '0;
         pulse_q    <= '0;
         valid_q    <= 1'b0;
         code_q     <= '0;
         overrun_q  <= 1'b0;
      end else begin
         slow_s1_q  <= slow_s1_d;
         slow_s2_q  <= slow_s2_d;
         slow_dly_q <= slow_dly_d;
         btn_s1_q   <= btn_s1_d;
         btn_s2_q   <= btn_s2_d;
         cnt_q      <= cnt_d;
         level_q    <= level_d;
         pulse_q    <= pulse_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         overrun_q  <= overrun_d;
      end
   end

   assign btn_level = level_q;
   assign btn_pulse = pulse_q;
   assign key_valid = valid_q;
   assign key_code  = code_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios with literal checks
// plus randomized buttons/acks compared every cycle against a sample-history model.
module tb_button_conditioner;
   localparam int N  = 5;
   localparam int SS = 4;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          slow_clk = 1'b0;
   logic [N-1:0]  btn_raw;
   logic          key_ack;
   logic [N-1:0]  btn_level;
   logic [N-1:0]  btn_pulse;
   logic          key_valid;
   logic [CW-1:0] key_code;
   logic          overrun;

   int n_cmp = 0;
   int n_bad = 0;
   int pcnt0 = 0;
   int pcnt_any = 0;
   bit started = 0;

   button_conditioner #(.N_BTN(N), .STABLE_SAMPLES(SS), .CODE_W(CW)) dut (
      .clk(clk), .rst(rst), .slow_clk(slow_clk), .btn_raw(btn_raw),
      .key_ack(key_ack), .btn_level(btn_level), .btn_pulse(btn_pulse),
      .key_valid(key_valid), .key_code(key_code), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // slow_clk toggles every 8 clk cycles, changed away from the rising edge.
   int sc = 0;
   always @(negedge clk) begin
      sc++;
      if (sc == 8) begin
         sc = 0;
         slow_clk = ~slow_clk;
      end
   end

   // Reference model: histories of sampled inputs, run-length debounce, event slot.
   bit           sh [3];
   bit [N-1:0]   rh [2];
   int           run_m [N];
   bit [N-1:0]   lvl_m, pul_m;
   bit           val_m, ovr_m;
   int           code_m;
   always @(posedge clk) begin : model
      bit [N-1:0] p, s, nl;
      bit         tk, free, ack_hit, drop;
      int         low;
      if (rst) begin
         sh = '{0, 0, 0};
         rh = '{0, 0};
         for (int i = 0; i < N; i++) run_m[i] = 0;
         lvl_m = 0; pul_m = 0; val_m = 0; ovr_m = 0; code_m = 0;
      end else begin
         p = pul_m;
         ack_hit = key_ack && val_m;
         if (p == 0) begin
            if (ack_hit) begin
               val_m = 0;
               ovr_m = 0;
            end
         end else begin
            free = !val_m || key_ack;
            low = 0;
            for (int i = N - 1; i >= 0; i--) if (p[i]) low = i;
            if (free) begin
               val_m  = 1;
               code_m = low;
            end
            drop = !free || ($countones(p) > 1);
            if (drop) ovr_m = 1;
            else if (ack_hit) ovr_m = 0;
         end
         tk = sh[1] && !sh[2];
         s  = rh[1];
         nl = lvl_m;
         if (tk) begin
            for (int i = 0; i < N; i++) begin
               if (s[i] != lvl_m[i]) begin
                  run_m[i]++;
                  if (run_m[i] == SS) begin
                     nl[i] = s[i];
                     run_m[i] = 0;
                  end
               end else begin
                  run_m[i] = 0;
               end
            end
         end
         pul_m = nl & ~lvl_m;
         lvl_m = nl;
         sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = slow_clk;
         rh[1] = rh[0]; rh[0] = btn_raw;
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle compare of all outputs against the model.
   always @(posedge clk) begin
      #1;
      if (started && !rst)
         chk("model", {btn_level, btn_pulse, key_valid, key_code, overrun},
             {lvl_m, pul_m, val_m, CW'(code_m), ovr_m});
   end

   // Pulse counters used by the directed scenarios.
   always @(posedge clk) begin
      #1;
      if (!rst && btn_pulse[0]) pcnt0++;
      if (!rst && btn_pulse != 0) pcnt_any++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pulse(string nm, int maxc);
      bit found;
      found = 0;
      for (int i = 0; i < maxc && !found; i++) begin
         step();
         if (btn_pulse != 0) found = 1;
      end
      chk({nm, "_pulse_seen"}, 32'(found), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; key_ack = 0; btn_raw = '0;
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (2) step();
   endtask

   initial begin
      int hold;
      rst = 1; key_ack = 0; btn_raw = '0;
      repeat (3) @(negedge clk);
      chk("reset_outputs", {btn_level, btn_pulse, key_valid, key_code, overrun}, 0);
      rst = 0;
      started = 1;

      // Clean press on button 2.
      btn_raw = 5'b00100;
      wait_pulse("clean", 200);
      chk("clean_pulse", btn_pulse, 5'b00100);
      step();
      chk("clean_pulse_one_cycle", btn_pulse, 0);
      chk("clean_valid", key_valid, 1);
      chk("clean_code", key_code, 2);
      chk("clean_level", btn_level, 5'b00100);

      // Press button 1 with the slot busy.
      btn_raw = 5'b00110;
      wait_pulse("busy", 200);
      chk("busy_pulse", btn_pulse, 5'b00010);
      step();
      chk("busy_overrun", overrun, 1);
      chk("busy_code_kept", key_code, 2);
      key_ack = 1;
      step();
      key_ack = 0;
      chk("ack_valid_clear", key_valid, 0);
      chk("ack_overrun_clear", overrun, 0);

      // Ack coincident with a new pulse.
      btn_raw = 5'b01110;
      wait_pulse("b3", 200);
      step();
      chk("b3_code", key_code, 3);
      btn_raw = 5'b11110;
      wait_pulse("b4", 200);
      chk("b4_pulse", btn_pulse, 5'b10000);
      key_ack = 1;
      step();
      key_ack = 0;
      chk("coinc_valid", key_valid, 1);
      chk("coinc_code", key_code, 4);
      chk("coinc_overrun", overrun, 0);

      // Simultaneous presses of buttons 1 and 3.
      do_reset();
      btn_raw = 5'b01010;
      wait_pulse("simul", 200);
      chk("simul_pulse", btn_pulse, 5'b01010);
      step();
      chk("simul_code", key_code, 1);
      chk("simul_overrun", overrun, 1);

      // Bounce rejection on button 0.
      do_reset();
      pcnt0 = 0;
      @(negedge slow_clk); btn_raw[0] = 1;
      repeat (3) @(posedge slow_clk);
      @(negedge slow_clk); btn_raw[0] = 0;
      @(posedge slow_clk);
      @(negedge slow_clk); btn_raw[0] = 1;
      chk("bounce_no_pulse", pcnt0, 0);
      repeat (3) @(posedge slow_clk);
      repeat (8) step();
      chk("bounce_level_low", btn_level, 0);
      wait_pulse("bounce", 40);
      chk("bounce_pulse", btn_pulse, 5'b00001);
      repeat (5) step();
      chk("bounce_one_pulse", pcnt0, 1);
      btn_raw[0] = 0;
      repeat (6) @(posedge slow_clk);
      repeat (8) step();
      chk("release_no_pulse", pcnt0, 1);
      chk("release_level", btn_level, 0);

      // Reset in the middle of a debounce run.
      do_reset();
      btn_raw = 5'b00010;
      wait_pulse("pre_rst", 200);
      step();
      @(negedge slow_clk); btn_raw = 5'b00110;
      repeat (2) @(posedge slow_clk);
      repeat (6) step();
      #2 rst = 1;
      #1 chk("rst_async_clear", {btn_level, btn_pulse, key_valid, key_code, overrun}, 0);
      repeat (3) step();
      @(negedge slow_clk);
      rst = 0;
      pcnt_any = 0;
      repeat (3) @(posedge slow_clk);
      repeat (8) step();
      chk("rst_no_early_pulse", pcnt_any, 0);
      wait_pulse("post_rst", 40);
      chk("post_rst_pulse", btn_pulse, 5'b00110);
      step();
      chk("post_rst_code", key_code, 1);
      chk("post_rst_overrun", overrun, 1);

      // Randomized buttons, acks and occasional resets against the model.
      do_reset();
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         rst = 0;
         if (hold == 0) begin
            if ($urandom_range(0, 2) == 0) btn_raw = btn_raw ^ N'($urandom);
            else btn_raw = btn_raw ^ (N'(1) << $urandom_range(0, N - 1));
            hold = $urandom_range(1, 90);
         end
         hold--;
         key_ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 1499) == 0) rst = 1;
      end
      rst = 0;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
